// File: rtl/pkt_reader_pkg.sv
// Shared types for the packet reader: FSM state encoding and header length-field layout.
package pkt_reader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_POP  = 2'd2
   } state_t;

   // Length field sits in the low bits of the header byte.
   localparam int LEN_LSB = 0;
   localparam int LEN_MIN = 1;

endpackage

// File: rtl/pkt_reader.sv
// Drains one FIFO entry per packet onto a registered valid/ready byte stream.
// Define PKT_READER_VARLEN_EN to take the packet length from the header byte.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | waiting for a non-empty FIFO; header byte loaded on exit
// ST_SEND | streaming bytes 0..N-1 of the head entry
// ST_POP  | one-cycle rinc pulse, then back to ST_IDLE
module pkt_reader
   import pkt_reader_pkg::*;
#(
   parameter int WIDTH     = 11,
   parameter int UWIDTH    = 8,
   parameter int PTR_IN_SZ = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rempty,
   input  logic [UWIDTH-1:0]    rdata,
   output logic [PTR_IN_SZ-1:0] raddr_in,
   output logic                 rinc,
   output logic [UWIDTH-1:0]    out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_last,
   output logic                 len_err
);

   localparam logic [PTR_IN_SZ-1:0] N_FULL  = PTR_IN_SZ'(WIDTH);
   localparam logic [PTR_IN_SZ-1:0] N_ONE   = PTR_IN_SZ'(LEN_MIN);
   localparam logic [PTR_IN_SZ-1:0] IDX_ONE = PTR_IN_SZ'(1);

   state_t                state, state_nxt;
   logic [PTR_IN_SZ-1:0]  n_q, n_nxt, raddr_nxt, hdr_n;
   logic [UWIDTH-1:0]     data_nxt;
   logic                  valid_nxt, last_nxt;

`ifdef PKT_READER_VARLEN_EN
   logic [PTR_IN_SZ-1:0]  hdr_len;
   logic                  hdr_bad;

   assign hdr_len = rdata[LEN_LSB +: PTR_IN_SZ];
   assign hdr_bad = (hdr_len == '0) || (hdr_len > N_FULL);
   assign hdr_n   = hdr_bad ? N_ONE : hdr_len;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         len_err <= 1'b0;
      end else if (state == ST_IDLE && !rempty && hdr_bad) begin
         len_err <= 1'b1;
      end
   end
`else
   assign hdr_n   = N_FULL;
   assign len_err = 1'b0;
`endif

   assign rinc = (state == ST_POP);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         n_q       <= N_ONE;
         raddr_in  <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end else begin
         state     <= state_nxt;
         n_q       <= n_nxt;
         raddr_in  <= raddr_nxt;
         out_data  <= data_nxt;
         out_valid <= valid_nxt;
         out_last  <= last_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      n_nxt     = n_q;
      raddr_nxt = raddr_in;
      data_nxt  = out_data;
      valid_nxt = out_valid;
      last_nxt  = out_last;
      case (state)
         ST_IDLE: begin
            raddr_nxt = '0;
            if (!rempty) begin
               data_nxt  = rdata;
               valid_nxt = 1'b1;
               n_nxt     = hdr_n;
               last_nxt  = (hdr_n == N_ONE);
               raddr_nxt = IDX_ONE;
               state_nxt = ST_SEND;
            end
         end
         ST_SEND: begin
            if (out_ready) begin
               if (out_last) begin
                  valid_nxt = 1'b0;
                  last_nxt  = 1'b0;
                  raddr_nxt = '0;
                  state_nxt = ST_POP;
               end else begin
                  data_nxt = rdata;
                  last_nxt = (raddr_in == n_q - IDX_ONE);
                  // Park on the final index so raddr_in never walks past the entry.
                  if (raddr_in != n_q - IDX_ONE) begin
                     raddr_nxt = raddr_in + IDX_ONE;
                  end
               end
            end
         end
         ST_POP: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_pkt_reader.sv
// Self-checking bench for pkt_reader: FIFO model plus per-cycle stream checks against packet rules.
module tb_pkt_reader;

   localparam int WIDTH     = 11;
   localparam int UWIDTH    = 8;
   localparam int PTR_IN_SZ = 4;
   localparam int DEPTH     = 8;
`ifdef PKT_READER_VARLEN_EN
   localparam bit VARLEN = 1'b1;
`else
   localparam bit VARLEN = 1'b0;
`endif

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 rempty;
   logic [UWIDTH-1:0]    rdata;
   logic [PTR_IN_SZ-1:0] raddr_in;
   logic                 rinc;
   logic [UWIDTH-1:0]    out_data;
   logic                 out_valid;
   logic                 out_ready = 1'b0;
   logic                 out_last;
   logic                 len_err;

   pkt_reader #(.WIDTH(WIDTH), .UWIDTH(UWIDTH), .PTR_IN_SZ(PTR_IN_SZ)) dut (
      .clk       (clk),
      .rst       (rst),
      .rempty    (rempty),
      .rdata     (rdata),
      .raddr_in  (raddr_in),
      .rinc      (rinc),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .len_err   (len_err)
   );

   always #5 clk = ~clk;

   // FIFO model: entries written by the stimulus, popped by rinc.
   logic [UWIDTH-1:0] mem [DEPTH][WIDTH];
   int wr_cnt = 0;
   int rd_cnt = 0;
   int ra;

   assign ra     = int'(raddr_in);
   assign rempty = (wr_cnt == rd_cnt);
   assign rdata  = (ra < WIDTH) ? mem[rd_cnt % DEPTH][ra] : 8'hxx;

   always @(posedge clk) begin
      if (rinc) rd_cnt <= rd_cnt + 1;
   end

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int exp_idx = 0;
   bit exp_rinc = 1'b0;
   bit exp_len_err = 1'b0;
   bit prev_valid = 1'b0;
   bit prev_ready = 1'b0;
   logic [UWIDTH-1:0] prev_data = '0;
   logic prev_last = 1'b0;
   int hdr_cyc_prev = 0;
   int hdr_cyc_last = 0;

   function automatic int model_len(input logic [7:0] hdr);
      int n;
      n = int'(hdr[3:0]);
      if (!VARLEN) return WIDTH;
      return (n == 0 || n > WIDTH) ? 1 : n;
   endfunction

   function automatic bit model_bad(input logic [7:0] hdr);
      int n;
      n = int'(hdr[3:0]);
      return VARLEN && (n == 0 || n > WIDTH);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] hdr);
      mem[wr_cnt % DEPTH][0] = hdr;
      for (int i = 1; i < WIDTH; i++) mem[wr_cnt % DEPTH][i] = 8'($urandom);
      wr_cnt++;
   endtask

   // One clock: sample at negedge, compare against the packet model, then drive out_ready.
   task automatic tick(input logic rdy);
      logic [7:0] hdr;
      int n;
      @(negedge clk);
      cyc++;
      if (prev_valid && !prev_ready) begin
         chk("stall_valid", 32'(out_valid), 32'd1);
         chk("stall_data", 32'(out_data), 32'(prev_data));
         chk("stall_last", 32'(out_last), 32'(prev_last));
      end
      chk("rinc", 32'(rinc), 32'(exp_rinc));
      exp_rinc = 1'b0;
      chk("raddr_range", 32'(raddr_in <= PTR_IN_SZ'(WIDTH - 1)), 32'd1);
      if (out_valid) begin
         hdr = mem[rd_cnt % DEPTH][0];
         n = model_len(hdr);
         if (!prev_valid) begin
            hdr_cyc_prev = hdr_cyc_last;
            hdr_cyc_last = cyc;
         end
         if (exp_idx == 0 && model_bad(hdr)) exp_len_err = 1'b1;
         chk("data", 32'(out_data), 32'(mem[rd_cnt % DEPTH][exp_idx]));
         chk("last", 32'(out_last), 32'(exp_idx == n - 1));
         if (rdy) begin
            if (exp_idx == n - 1) begin
               exp_idx = 0;
               exp_rinc = 1'b1;
            end else begin
               exp_idx++;
            end
         end
      end
      chk("len_err", 32'(len_err), 32'(exp_len_err));
      out_ready = rdy;
      prev_valid = out_valid;
      prev_ready = rdy;
      prev_data = out_data;
      prev_last = out_last;
   endtask

   task automatic drain(input bit rand_ready);
      int budget;
      budget = 0;
      do begin
         tick(rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
         budget++;
      end while (!(rempty && !out_valid && !rinc) && budget < 2000);
      if (budget >= 2000) chk("drain_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      int rd_snap;
      int guard;

      // Reset values
      #1 rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_last", 32'(out_last), 32'd0);
      chk("rst_data", 32'(out_data), 32'd0);
      chk("rst_raddr", 32'(raddr_in), 32'd0);
      chk("rst_rinc", 32'(rinc), 32'd0);
      chk("rst_len_err", 32'(len_err), 32'd0);
      rst = 1'b1;

      // Empty FIFO: nothing moves
      repeat (20) tick(1'b1);
      chk("empty_valid", 32'(out_valid), 32'd0);
      chk("empty_raddr", 32'(raddr_in), 32'd0);

      // Two back-to-back entries, out_ready held high
      push(8'h04);
      push({4'($urandom), 4'd9});
      tick(1'b1);
      chk("first_latency", 32'(out_valid), 32'd1);
      drain(1'b0);
      chk("packet_period", 32'(hdr_cyc_last - hdr_cyc_prev), 32'(model_len(8'h04) + 2));
      chk("pops_b2b", 32'(rd_cnt), 32'(wr_cnt));

      // out_ready 1,0,0,1 mid-packet
      push(8'h06);
      tick(1'b1);
      tick(1'b1);
      tick(1'b0);
      tick(1'b0);
      tick(1'b1);
      drain(1'b0);
      chk("pops_stall", 32'(rd_cnt), 32'(wr_cnt));

      // Reset while byte idx2 is pending
      push(8'h07);
      guard = 0;
      do begin
         tick(1'b1);
         guard++;
      end while (exp_idx != 2 && guard < 50);
      chk("reach_idx2", 32'(exp_idx), 32'd2);
      out_ready = 1'b0;
      #2 rst = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_data", 32'(out_data), 32'd0);
      chk("mid_rst_last", 32'(out_last), 32'd0);
      chk("mid_rst_raddr", 32'(raddr_in), 32'd0);
      chk("mid_rst_rinc", 32'(rinc), 32'd0);
      exp_idx = 0;
      exp_rinc = 1'b0;
      exp_len_err = 1'b0;
      prev_valid = 1'b0;
      prev_ready = 1'b0;
      rd_snap = rd_cnt;
      tick(1'b0);
      tick(1'b0);
      rst = 1'b1;
      tick(1'b1);
      chk("resend_valid", 32'(out_valid), 32'd1);
      chk("resend_hdr", 32'(out_data), 32'(mem[rd_snap % DEPTH][0]));
      drain(1'b0);
      chk("resend_pops", 32'(rd_cnt), 32'(rd_snap + 1));

      // Illegal header lengths
      push(8'h00);
      push(8'h0C);
      drain(1'b0);
      chk("len_err_sticky", 32'(len_err), 32'(VARLEN));
      chk("pops_bad", 32'(rd_cnt), 32'(wr_cnt));

      // Randomized entries and backpressure
      for (int p = 0; p < 6; p++) begin
         push({4'($urandom), 4'($urandom_range(1, WIDTH))});
         if (p % 2 == 1) drain(1'b1);
      end
      drain(1'b1);
      chk("pops_random", 32'(rd_cnt), 32'(wr_cnt));
      chk("final_len_err", 32'(len_err), 32'(exp_len_err));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
